serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 109 ++++++++++
 tb/tb_serial_tx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Serial word transmitter: shifts a parallel word out one bit per falling
// edge of a slow serial clock, gating that clock to the receiver.
module serial_tx #(
  parameter int unsigned BITS                 = 8,
  parameter bit          LOWBIT_FIRST         = 1'b1,
  parameter bit          SERIAL_CLK_INACTIVE  = 1'b1,
  parameter bit          SERIAL_DATA_INACTIVE = 1'b1
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_serial_clk,
  input  logic            in_enable,
  input  logic [BITS-1:0] in_data,
  output logic            out_ready,
  output logic            out_next_word,
  output logic            out_clk,
  output logic            out_serial
);

  localparam int unsigned CTR_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(BITS - 1);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_TRANSMIT = 1'b1
  } state_t;

  state_t            r_state;
  logic [CTR_W-1:0]  r_ctr;
  logic [BITS-1:0]   r_shift;
  logic              r_sclk_d;
  logic              r_next_word;

  state_t            w_state_nx;
  logic [CTR_W-1:0]  w_ctr_nx;
  logic [BITS-1:0]   w_shift_nx;
  logic              w_next_word_nx;
  logic              w_fall;
  logic [CTR_W-1:0]  w_bit_idx;

  // Serial clock falling event: was high last cycle, low now.
  assign w_fall = r_sclk_d & ~in_serial_clk;

  // State, datapath and serial-clock delay registers with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      r_state     <= S_IDLE;
      r_ctr       <= '0;
      r_shift     <= '0;
      r_sclk_d    <= 1'b0;
      r_next_word <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_ctr       <= w_ctr_nx;
      r_shift     <= w_shift_nx;
      r_sclk_d    <= in_serial_clk;
      r_next_word <= w_next_word_nx;
    end
  end

  // Next-state logic; words are latched only on a falling event at a word boundary.
  always_comb begin
    w_state_nx     = r_state;
    w_ctr_nx       = r_ctr;
    w_shift_nx     = r_shift;
    w_next_word_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && in_enable) begin
          w_shift_nx     = in_data;
          w_ctr_nx       = '0;
          w_state_nx     = S_TRANSMIT;
          w_next_word_nx = 1'b1;
        end
      end
      S_TRANSMIT: begin
        if (w_fall) begin
          if (r_ctr != CTR_MAX) begin
            w_ctr_nx = r_ctr + CTR_W'(1);
          end else if (in_enable) begin
            // Back-to-back word: no gap bit between words.
            w_shift_nx     = in_data;
            w_ctr_nx       = '0;
            w_next_word_nx = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Line outputs: inactive levels when idle, gated clock and current bit when busy.
  always_comb begin
    w_bit_idx  = LOWBIT_FIRST ? r_ctr : (CTR_MAX - r_ctr);
    out_ready  = 1'b1;
    out_clk    = SERIAL_CLK_INACTIVE;
    out_serial = SERIAL_DATA_INACTIVE;
    if (r_state == S_TRANSMIT) begin
      out_ready  = 1'b0;
      out_clk    = in_serial_clk;
      out_serial = r_shift[w_bit_idx];
    end
  end

  assign out_next_word = r_next_word;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: LSB-first and MSB-first instances driven in lockstep.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       en;
  logic [7:0] data;
  int         scnt = 0;

  logic rdy_l, nw_l, ck_l, sd_l;
  logic rdy_m, nw_m, ck_m, sd_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_tx #(.BITS(8), .LOWBIT_FIRST(1'b1), .SERIAL_CLK_INACTIVE(1'b1),
              .SERIAL_DATA_INACTIVE(1'b1)) dut_l (
    .in_clk(clk), .in_rst(rst), .in_serial_clk(sclk), .in_enable(en),
    .in_data(data), .out_ready(rdy_l), .out_next_word(nw_l),
    .out_clk(ck_l), .out_serial(sd_l));

  serial_tx #(.BITS(8), .LOWBIT_FIRST(1'b0), .SERIAL_CLK_INACTIVE(1'b1),
              .SERIAL_DATA_INACTIVE(1'b1)) dut_m (
    .in_clk(clk), .in_rst(rst), .in_serial_clk(sclk), .in_enable(en),
    .in_data(data), .out_ready(rdy_m), .out_next_word(nw_m),
    .out_clk(ck_m), .out_serial(sd_m));

  // Serial clock: 8 in_clk cycles per period, 4 high then 4 low.
  initial begin
    sclk = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      scnt = (scnt + 1) % 8;
      sclk = (scnt < 4);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_nw(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (nw_l === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("latch_pulse_seen", 32'(found), 32'd1);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_ready_l"}, 32'(rdy_l), 32'd1);
    chk({tag, "_ready_m"}, 32'(rdy_m), 32'd1);
    chk({tag, "_clk"},     32'(ck_l),  32'd1);
    chk({tag, "_serial"},  32'(sd_l),  32'd1);
    chk({tag, "_serial_m"},32'(sd_m),  32'd1);
    chk({tag, "_nw"},      32'(nw_l),  32'd0);
  endtask

  // Follows nw words from the first latch pulse; seq_* hold bits in time order.
  task automatic run_words(input int chg_at, input logic [7:0] chg_val,
                           input logic [15:0] seq_l, input logic [15:0] seq_m,
                           input int nw);
    bit   found;
    int   rises_l = 0;
    int   rises_m = 0;
    logic pl, pm;
    wait_nw(found);
    if (found) begin
      pl = ck_l;
      pm = ck_m;
      for (int c = 0; c < nw * 64; c++) begin
        if (c > 0) step();
        chk("bit_lsb_first", 32'(sd_l), 32'(seq_l[c / 8]));
        chk("bit_msb_first", 32'(sd_m), 32'(seq_m[c / 8]));
        chk("busy_ready",    32'(rdy_l), 32'd0);
        chk("clk_follow",    32'(ck_l), 32'(sclk));
        chk("next_word_l",   32'(nw_l), 32'((c % 64) == 0));
        chk("next_word_m",   32'(nw_m), 32'((c % 64) == 0));
        if (c > 0) begin
          if (ck_l === 1'b1 && pl === 1'b0 && rdy_l === 1'b0) rises_l++;
          if (ck_m === 1'b1 && pm === 1'b0 && rdy_m === 1'b0) rises_m++;
        end
        pl = ck_l;
        pm = ck_m;
        if (c == chg_at) data = chg_val;
        if (c == (nw - 1) * 64) en = 1'b0;
      end
      step();
      idle_chk("after_word");
      chk("clk_rises_l", 32'(rises_l), 32'(8 * nw));
      chk("clk_rises_m", 32'(rises_m), 32'(8 * nw));
    end
  endtask

  initial begin
    bit found;
    rst  = 1'b0;
    en   = 1'b0;
    data = 8'h00;
    step();
    step();
    idle_chk("reset");
    rst = 1'b1;
    step();
    idle_chk("idle_no_enable");

    // 0xC5: LSB order 1,0,1,0,0,0,1,1 ; MSB order 1,1,0,0,0,1,0,1
    data = 8'hC5; en = 1'b1;
    run_words(-1, 8'h00, 16'h00C5, 16'h00A3, 1);

    // 0x12: LSB order 0,1,0,0,1,0,0,0 ; MSB order 0,0,0,1,0,0,1,0
    data = 8'h12; en = 1'b1;
    run_words(-1, 8'h00, 16'h0012, 16'h0048, 1);

    // Back-to-back 0x12 then 0xF0 (MSB order of 0xF0 is 1,1,1,1,0,0,0,0)
    data = 8'h12; en = 1'b1;
    run_words(0, 8'hF0, 16'hF012, 16'h0F48, 2);

    // Reset during bit 3 aborts the word; the next word restarts at bit 0
    data = 8'hC5; en = 1'b1;
    wait_nw(found);
    en = 1'b0;
    for (int i = 0; i < 28; i++) step();
    chk("pre_reset_bit3", 32'(sd_l), 32'd0);
    rst = 1'b0;
    step();
    idle_chk("mid_reset");
    step();
    rst = 1'b1;
    data = 8'hC5; en = 1'b1;
    run_words(-1, 8'h00, 16'h00C5, 16'h00A3, 1);

    // in_data changed to 0x00 during bit 2 leaves the word in flight intact
    data = 8'hC5; en = 1'b1;
    run_words(20, 8'h00, 16'h00C5, 16'h00A3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
